// File: rtl/receiver.sv
// UART receiver (8N1, LSB first) that packs up to SIZE/8 received bytes into a
// SIZE-bit word, first byte in the most significant position.
module receiver #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SIZE         = 512
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RxD,
  input  logic [15:0]     d,
  output logic [SIZE-1:0] data,
  output logic            valid,
  output logic            busy,
  output logic            frame_error
);

  localparam int NBYTES = SIZE / 8;
  localparam int BW     = $clog2(CLKS_PER_BIT);
  localparam int IW     = $clog2(NBYTES) + 1;

  localparam logic [BW-1:0] BAUD_MID  = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] MAX_BYTES = IW'(NBYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [IW-1:0]   byte_idx_q, byte_idx_d;
  logic [IW-1:0]   target_q, target_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            fe_q, fe_d;

  logic            rx_fall;
  logic [12:0]     d_bytes;
  logic [IW-1:0]   msg_target;
  logic [IW-1:0]   byte_idx_inc;
  logic [NBYTES-1:0] lane_sel;

  assign rx_fall      = rx_prev_q & ~rx_s_q;
  assign d_bytes      = d[15:3];
  assign byte_idx_inc = byte_idx_q + IW'(1);

  // Zero or oversize lengths fall back to a full block.
  assign msg_target = (d_bytes == 13'd0 || d_bytes > 13'(NBYTES)) ? MAX_BYTES
                                                                  : IW'(d_bytes);

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign lane_sel[gi] = (byte_idx_q == IW'(gi));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    target_d   = target_q;
    data_d     = data_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    fe_d       = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_fall) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_q == BAUD_MID) begin
          baud_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            bit_d   = '0;
            if (byte_idx_q == '0) begin
              target_d = msg_target;
              data_d   = '0;
              busy_d   = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s_q;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (lane_sel[i]) begin
                data_d[SIZE-1-8*i -: 8] = shift_q;
              end
            end
            if (byte_idx_inc == target_q) begin
              valid_d    = 1'b1;
              byte_idx_d = '0;
              busy_d     = 1'b0;
            end else begin
              byte_idx_d = byte_idx_inc;
            end
          end else begin
            // Bad stop bit abandons the whole message, not just this byte.
            fe_d       = 1'b1;
            byte_idx_d = '0;
            busy_d     = 1'b0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      target_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_meta_q  <= RxD;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      target_q   <= target_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      fe_q       <= fe_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign frame_error = fe_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: directed table, corner sequences and a
// randomized byte stream checked against a message-level model.
module tb_receiver;

  localparam int CPB    = 16;
  localparam int SIZE   = 512;
  localparam int NBYTES = SIZE / 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            RxD = 1'b1;
  logic [15:0]     d = 16'd8;
  logic [SIZE-1:0] data;
  logic            valid;
  logic            busy;
  logic            frame_error;

  receiver #(.CLKS_PER_BIT(CPB), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .d(d),
    .data(data), .valid(valid), .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Message-level reference model: bytes collect until the length latched at
  // the first byte is reached; a bad stop bit throws the message away.
  logic [7:0]      m_bytes[$];
  int              m_tgt = 0;
  logic [SIZE-1:0] exp_q[$];
  int              exp_fe = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [SIZE-1:0] w;
    if (!ok) begin
      exp_fe++;
      m_bytes.delete();
      return;
    end
    if (m_bytes.size() == 0) begin
      m_tgt = int'(d) / 8;
      if (m_tgt == 0 || m_tgt > NBYTES) m_tgt = NBYTES;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == m_tgt) begin
      w = '0;
      for (int i = 0; i < m_bytes.size(); i++) w[SIZE-1-8*i -: 8] = m_bytes[i];
      exp_q.push_back(w);
      m_bytes.delete();
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int              n_valid = 0;
  int              n_fe = 0;
  int              busy_low = 0;
  bit              in_block = 0;
  logic [SIZE-1:0] last_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      if (valid && frame_error) chk("valid_and_frame_error", 1, 0);
      if (in_block && !busy) busy_low++;
      if (frame_error) n_fe++;
      if (valid) begin
        n_valid++;
        last_data = data;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("model_word", data, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    @(negedge clk) RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) RxD = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(ok);
    if (!ok) send_bit(1'b1);
  endtask

  typedef struct {
    logic [15:0] d;
    int          nbytes;
    logic [7:0]  first;
    int          exp_valids;
    logic [23:0] exp_top;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, f0;
    logic [7:0] b;

    vecs[0] = '{16'd8,  1, 8'hA5, 1, 24'hA50000};
    vecs[1] = '{16'd16, 2, 8'h10, 1, 24'h101100};
    vecs[2] = '{16'd12, 1, 8'h7E, 1, 24'h7E0000};
    vecs[3] = '{16'd24, 3, 8'h01, 1, 24'h010203};
    vecs[4] = '{16'd15, 1, 8'hC3, 1, 24'hC30000};

    repeat (5) @(negedge clk);
    chk("reset_data", data, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_error", frame_error, 0);
    reset = 1'b1;
    idle(3 * CPB);

    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; f0 = n_fe;
      d = vecs[i].d;
      for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].first + 8'(j), 1'b1);
      idle(CPB);
      $display("vector %0d: d=%0d bytes=%0d valids=%0d data_top=%h", i, vecs[i].d,
               vecs[i].nbytes, n_valid - v0, last_data[SIZE-1 -: 24]);
      chk("vec_valid_count", n_valid - v0, vecs[i].exp_valids);
      chk("vec_data_top", last_data[SIZE-1 -: 24], vecs[i].exp_top);
      chk("vec_data_low_zero", last_data[SIZE-25:0], 0);
      chk("vec_data_held", data, last_data);
      chk("vec_no_frame_error", n_fe - f0, 0);
      chk("vec_busy_idle", busy, 0);
    end

    // Glitch shorter than half a bit must be rejected.
    v0 = n_valid;
    @(negedge clk) RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("glitch_busy", busy, 0);
    idle(2 * CPB);
    chk("glitch_no_valid", n_valid - v0, 0);
    d = 16'd8;
    send_byte(8'h3C, 1'b1);
    idle(CPB);
    $display("glitch: then 0x3C -> data_top=%h", last_data[SIZE-1 -: 8]);
    chk("glitch_byte", last_data[SIZE-1 -: 8], 8'h3C);
    chk("glitch_valid_once", n_valid - v0, 1);

    // Framing error on 2nd byte, then a clean 2-byte message.
    v0 = n_valid; f0 = n_fe;
    d = 16'd16;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    chk("ferr_pulse", n_fe - f0, 1);
    chk("ferr_no_valid", n_valid - v0, 0);
    chk("ferr_busy_clear", busy, 0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(CPB);
    $display("framing: after error 0x33,0x44 -> data_top=%h", last_data[SIZE-1 -: 16]);
    chk("ferr_recover_data", last_data[SIZE-1 -: 16], 16'h3344);
    chk("ferr_recover_valid", n_valid - v0, 1);

    // Asynchronous reset in the 4th data bit of the 2nd byte.
    v0 = n_valid;
    d = 16'd24;
    send_byte(8'hAA, 1'b1);
    chk("rst_busy_before", busy, 1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk) RxD = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame_error", frame_error, 0);
    m_bytes.delete();
    exp_q.delete();
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    idle(2 * CPB);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(CPB);
    $display("reset mid-frame: fresh 01,02,03 -> data_top=%h", last_data[SIZE-1 -: 24]);
    chk("rst_recover_data", last_data[SIZE-1 -: 24], 24'h010203);
    chk("rst_recover_valid", n_valid - v0, 1);

    // Full 64-byte block, back to back.
    v0 = n_valid;
    d = 16'd512;
    busy_low = 0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == 1) in_block = 1;
      send_byte(8'(i), 1'b1);
      if (i == NBYTES - 2) in_block = 0;
      if (i == NBYTES - 2) chk("block_no_early_valid", n_valid - v0, 0);
    end
    idle(CPB);
    $display("full block: valids=%0d first=%h last=%h", n_valid - v0,
             last_data[SIZE-1 -: 8], last_data[7:0]);
    chk("block_valid_once", n_valid - v0, 1);
    chk("block_first_byte", last_data[SIZE-1 -: 8], 8'h00);
    chk("block_last_byte", last_data[7:0], 8'h3F);
    chk("block_busy_held", busy_low, 0);

    // d = 0 clamps to a full block.
    v0 = n_valid;
    d = 16'd0;
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      if (i == NBYTES - 2) chk("clamp0_no_early_valid", n_valid - v0, 0);
    end
    idle(CPB);
    $display("clamp d=0: valids=%0d after %0d bytes", n_valid - v0, NBYTES);
    chk("clamp0_valid", n_valid - v0, 1);

    // Randomized stream: random lengths, gaps, bad stops, mid-message d changes.
    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom_range(8, 47));
      b = 8'($urandom_range(0, 255));
      send_byte(b, ($urandom_range(0, 7) != 0));
      idle($urandom_range(0, 20));
    end
    idle(2 * CPB);
    chk("rand_frame_errors", n_fe, exp_fe);
    chk("rand_pending_words", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
